// File: rtl/multiword_add_seq.sv
// -----------------------------------------------------------------------------
// multiword_add_seq
//
// Sequencer that performs a WORDS x 32-bit unsigned addition with an external,
// purely combinational 32-bit adder. A new operand set is taken over a
// valid/ready handshake. The adder then sees one slice per cycle, least
// significant slice first, with the carry chained through a register. The
// wide result is then held on a valid/ready output until it is taken.
//
// Parameters
//   WORDS     : number of 32-bit slices per operand (1..8)
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operand set offered
//   in_ready  : block idle and able to accept an operand set
//   in_a/in_b : wide operands (32*WORDS bits)
//   in_cin    : carry into slice 0
//   add_a/add_b/add_cin : slice operands and carry driven to the adder
//   add_sum/add_cout    : adder result for the slice currently driven
//   out_valid : wide result available
//   out_ready : downstream accepts the result
//   out_sum   : wide sum (32*WORDS bits), holds until the next operation
//   out_cout  : final carry-out, holds until the next operation
//   out_ovf   : signed overflow of the full-width add (only with the macro)
//
// Optional feature macro: MULTIWORD_ADD_OVF_EN (adds out_ovf)
// -----------------------------------------------------------------------------
module multiword_add_seq #(
    parameter int WORDS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*WORDS-1:0]  in_a,
    input  logic [32*WORDS-1:0]  in_b,
    input  logic                 in_cin,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_cin,
    input  logic [31:0]          add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*WORDS-1:0]  out_sum,
    output logic                 out_cout
`ifdef MULTIWORD_ADD_OVF_EN
    ,
    output logic                 out_ovf
`endif
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int MSB   = 32*WORDS - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    // One-hot so that in_ready and out_valid come straight off a flop.
    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_RUN  = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    logic [2:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [32*WORDS-1:0] a_q, a_d;
    logic [32*WORDS-1:0] b_q, b_d;
    logic [32*WORDS-1:0] sum_q, sum_d;
    logic                cout_q, cout_d;
    logic [IDX_W+4:0]    slice_base_s;
`ifdef MULTIWORD_ADD_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    // Bit offset of the current slice (idx * 32).
    assign slice_base_s = {idx_q, 5'b00000};

    // Next-state, slice selection and result capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef MULTIWORD_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        add_a   = 32'h0000_0000;
        add_b   = 32'h0000_0000;
        add_cin = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                add_a   = a_q[slice_base_s +: 32];
                add_b   = b_q[slice_base_s +: 32];
                add_cin = carry_q;
                sum_d[slice_base_s +: 32] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    // Last slice: publish the final carry (and overflow)
                    // together with the top slice of the sum.
                    cout_d  = add_cout;
`ifdef MULTIWORD_ADD_OVF_EN
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (add_sum[31] != a_q[MSB]);
`endif
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                // Illegal encoding: fall back to a safe idle.
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {(32*WORDS){1'b0}};
            b_q     <= {(32*WORDS){1'b0}};
            sum_q   <= {(32*WORDS){1'b0}};
            cout_q  <= 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = state_q[0];
    assign out_valid = state_q[2];
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
`ifdef MULTIWORD_ADD_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// -----------------------------------------------------------------------------
// Testbench for multiword_add_seq: one instance with WORDS=2 and one with
// WORDS=1, each next to a behavioural 32-bit adder. Expected results come from
// plain wide arithmetic.
// -----------------------------------------------------------------------------
module tb_multiword_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WORDS=2 instance signals
    logic        iv2, ir2, ic2, ac2, aco2, ov2, or2, oc2;
    logic [63:0] ia2, ib2, os2;
    logic [31:0] aa2, ab2, as2;
    // WORDS=1 instance signals
    logic        iv1, ir1, ic1, ac1, aco1, ov1, or1, oc1;
    logic [31:0] ia1, ib1, os1;
    logic [31:0] aa1, ab1, as1;
`ifdef MULTIWORD_ADD_OVF_EN
    logic        of2, of1;
`endif

    // Behavioural combinational adders.
    assign {aco2, as2} = {1'b0, aa2} + {1'b0, ab2} + {32'd0, ac2};
    assign {aco1, as1} = {1'b0, aa1} + {1'b0, ab1} + {32'd0, ac1};

    multiword_add_seq #(.WORDS(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(iv2), .in_ready(ir2), .in_a(ia2), .in_b(ib2), .in_cin(ic2),
        .add_a(aa2), .add_b(ab2), .add_cin(ac2), .add_sum(as2), .add_cout(aco2),
        .out_valid(ov2), .out_ready(or2), .out_sum(os2), .out_cout(oc2)
`ifdef MULTIWORD_ADD_OVF_EN
        , .out_ovf(of2)
`endif
    );

    multiword_add_seq #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .in_a(ia1), .in_b(ib1), .in_cin(ic1),
        .add_a(aa1), .add_b(ab1), .add_cin(ac1), .add_sum(as1), .add_cout(aco1),
        .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_cout(oc1)
`ifdef MULTIWORD_ADD_OVF_EN
        , .out_ovf(of1)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] exp_sum;
        logic        exp_cout;
        logic        exp_cin_run2;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete operation on the WORDS=2 instance, holding the result
    // for 'hold' cycles before taking it.
    task automatic run2(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input int hold, output logic [63:0] sum, output logic cout,
                        output logic ovf, output int lat, output logic cin_run2);
        @(negedge clk);
        chk("w2_in_ready_idle", ir2, 1);
        ia2 = a; ib2 = b; ic2 = cin; iv2 = 1'b1;
        @(posedge clk);                      // accept edge
        @(negedge clk);
        iv2 = 1'b0;
        ia2 = {$urandom, $urandom};          // must not affect the result
        ib2 = {$urandom, $urandom};
        ic2 = 1'($urandom_range(0, 1));
        lat = 1;
        cin_run2 = 1'b0;
        while (!ov2 && lat < 20) begin
            if (lat == 2) cin_run2 = ac2;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("w2_out_valid_seen", ov2, 1);
        sum  = os2;
        cout = oc2;
`ifdef MULTIWORD_ADD_OVF_EN
        ovf  = of2;
`else
        ovf  = 1'b0;
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("w2_hold_valid", ov2, 1);
            chk("w2_hold_sum", os2, sum);
            chk("w2_hold_cout", oc2, cout);
            chk("w2_hold_in_ready", ir2, 0);
        end
        or2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or2 = 1'b0;
        chk("w2_valid_dropped", ov2, 0);
        chk("w2_in_ready_back", ir2, 1);
        chk("w2_sum_kept", os2, sum);
    endtask

    // One complete operation on the WORDS=1 instance.
    task automatic run1(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        output logic [31:0] sum, output logic cout, output int lat);
        @(negedge clk);
        ia1 = a; ib1 = b; ic1 = cin; iv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0;
        ia1 = $urandom;
        lat = 1;
        while (!ov1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("w1_out_valid_seen", ov1, 1);
        sum  = os1;
        cout = oc1;
        or1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or1 = 1'b0;
        chk("w1_valid_dropped", ov1, 0);
    endtask

    initial begin
        logic [63:0] s, ra, rb;
        logic [64:0] ref_full;
        logic [31:0] s1, ra1, rb1;
        logic [32:0] ref1;
        logic        c, ovf, c1r, rc;
        int          lat;

        vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b1};
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0, 1'b1};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                    64'h0000_0000_0000_0001, 1'b1, 1'b0};

        rst = 1'b1;
        iv2 = 1'b0; or2 = 1'b0; ia2 = 64'h0; ib2 = 64'h0; ic2 = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; ia1 = 32'h0; ib1 = 32'h0; ic1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", ir2, 1);
        chk("rst_out_valid", ov2, 0);
        chk("rst_out_sum", os2, 0);
        chk("rst_out_cout", oc2, 0);
        chk("rst_add_a", aa2, 0);
        chk("rst_w1_in_ready", ir1, 1);
        chk("rst_w1_out_valid", ov1, 0);
        rst = 1'b0;

        // Directed table on the WORDS=2 instance; entry 2 is held 5 cycles.
        for (int i = 0; i < 4; i++) begin
            run2(vecs[i].a, vecs[i].b, vecs[i].cin, (i == 2) ? 5 : 0, s, c, ovf, lat, c1r);
            chk($sformatf("tbl%0d_sum", i), s, vecs[i].exp_sum);
            chk($sformatf("tbl%0d_cout", i), c, vecs[i].exp_cout);
            chk($sformatf("tbl%0d_latency", i), lat, 3);
            chk($sformatf("tbl%0d_add_cin_run2", i), c1r, vecs[i].exp_cin_run2);
        end

        // Reset during the first RUN cycle, then 3+4.
        @(negedge clk);
        ia2 = 64'hDEAD_BEEF_0000_0001; ib2 = 64'h1111_2222_3333_4444; ic2 = 1'b1; iv2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv2 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", ov2, 0);
        chk("midrst_in_ready", ir2, 1);
        run2(64'd3, 64'd4, 1'b0, 0, s, c, ovf, lat, c1r);
        chk("midrst_sum", s, 64'd7);
        chk("midrst_cout", c, 0);

        // Random operands against wide arithmetic.
        for (int i = 0; i < 12; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 0) rb = ~ra;            // long carry chain
            rc = 1'($urandom_range(0, 1));
            ref_full = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
            run2(ra, rb, rc, 0, s, c, ovf, lat, c1r);
            chk($sformatf("rnd%0d_sum", i), s, ref_full[63:0]);
            chk($sformatf("rnd%0d_cout", i), c, ref_full[64]);
            chk($sformatf("rnd%0d_latency", i), lat, 3);
`ifdef MULTIWORD_ADD_OVF_EN
            chk($sformatf("rnd%0d_ovf", i), ovf,
                (ra[63] == rb[63]) && (ref_full[63] != ra[63]));
`endif
        end

`ifdef MULTIWORD_ADD_OVF_EN
        run2(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, s, c, ovf, lat, c1r);
        chk("ovf_pos_ovf", ovf, 1);
        chk("ovf_pos_cout", c, 0);
        run2(64'h1, 64'h1, 1'b0, 0, s, c, ovf, lat, c1r);
        chk("ovf_none_ovf", ovf, 0);
        chk("ovf_none_sum", s, 64'h2);
`endif

        // WORDS=1 instance.
        run1(32'hFFFF_FFFF, 32'h1, 1'b0, s1, c, lat);
        chk("w1_sum", s1, 32'h0);
        chk("w1_cout", c, 1);
        chk("w1_latency", lat, 2);
        for (int i = 0; i < 6; i++) begin
            ra1 = $urandom;
            rb1 = $urandom;
            rc  = 1'($urandom_range(0, 1));
            ref1 = {1'b0, ra1} + {1'b0, rb1} + {32'd0, rc};
            run1(ra1, rb1, rc, s1, c, lat);
            chk($sformatf("w1_rnd%0d_sum", i), s1, ref1[31:0]);
            chk($sformatf("w1_rnd%0d_cout", i), c, ref1[32]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
